// File: rtl/uart_apb_master.sv
// UART-framed APB requester: decodes byte-stream read/write commands, runs one
// APB transfer per frame and streams a status byte (plus read data) back out.
module uart_apb_master #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_paddr,
    output logic [31:0] m_pwdata,
    output logic [3:0]  m_pstrb,
    output logic [2:0]  m_pprot,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr,
    output logic        busy
);
    localparam int unsigned      TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [7:0]       CMD_WR  = 8'h57;
    localparam logic [7:0]       CMD_RD  = 8'h52;
    localparam logic [7:0]       RSP_OK  = 8'h4B;
    localparam logic [7:0]       RSP_ERR = 8'h45;
    localparam logic [7:0]       RSP_BAD = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_q, rsp_d;
    logic [2:0]        rsp_left_q, rsp_left_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_q      <= '0;
            rsp_left_q <= '0;
            to_cnt_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_q      <= rsp_d;
            rsp_left_q <= rsp_left_d;
            to_cnt_q   <= to_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_d      = rsp_q;
        rsp_left_d = rsp_left_q;
        to_cnt_d   = to_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        op_wr_d = (rx_data == CMD_WR);
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_BAD;
                        rsp_left_d = '0;
                        state_d    = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d = {addr_q[23:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (op_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            // APB payload registers are loaded on SETUP entry so they
                            // keep their last value once the transfer is over.
                            paddr_d  = addr_d;
                            pwrite_d = 1'b0;
                            pwdata_d = '0;
                            pstrb_d  = 4'h0;
                            state_d  = S_SETUP;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        paddr_d  = addr_q;
                        pwrite_d = 1'b1;
                        pwdata_d = wdata_d;
                        pstrb_d  = 4'hF;
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                to_cnt_d = '0;
                state_d  = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_pready) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                    rsp_d      = m_prdata;
                    if (m_pslverr) begin
                        tx_data_d  = RSP_ERR;
                        rsp_left_d = '0;
                    end else begin
                        tx_data_d  = RSP_OK;
                        rsp_left_d = pwrite_q ? 3'd0 : 3'd4;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_ERR;
                    rsp_left_d = '0;
                    state_d    = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    if (rsp_left_q == 3'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d  = rsp_q[31:24];
                        rsp_d      = {rsp_q[23:0], 8'h00};
                        rsp_left_d = rsp_left_q - 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign m_penable = (state_q == S_ACCESS);
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pwdata  = pwdata_q;
    assign m_pstrb   = pstrb_q;
    assign m_pprot   = 3'b000;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 Parameter TIMEOUT, default 1023, SHALL set the max ACCESS-phase cycles waiting for m_pready before abort.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  one-cycle strobe: received UART byte on rx_data.
REQ-005 rx_data  input  8  received byte, valid only with rx_valid.
REQ-006 tx_valid  output  1  response byte offered to UART transmitter.
REQ-007 tx_data  output  8  response byte, held stable while tx_valid=1.
REQ-008 tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready.
REQ-009 m_psel, m_penable, m_pwrite  output  1 each  APB requester controls.
REQ-010 m_paddr  output  32; m_pwdata  output  32; m_pstrb  output  4; m_pprot  output  3  APB requester payload.
REQ-011 m_prdata  input  32; m_pready  input  1; m_pslverr  input  1  APB completer response.
REQ-012 busy  output  1  high whenever state != IDLE.

Function
REQ-013 Frame format, all multi-byte fields MSB first: write = 0x57, addr[4], data[4]; read = 0x52, addr[4].
REQ-014 States SHALL be IDLE, ADDR, DATA, SETUP, ACCESS, RESP; 2-bit byte counter indexes ADDR/DATA bytes.
REQ-015 IDLE: rx_valid with 0x57 or 0x52 SHALL latch op and go to ADDR, counter=0; any other byte SHALL queue response 0x3F and go to RESP.
REQ-016 ADDR: each rx_valid shifts byte into addr (addr <= {addr[23:0],byte}); after 4th byte go DATA (write) or SETUP (read).
REQ-017 DATA: 4 bytes shifted into wdata likewise; after 4th byte go SETUP.
REQ-018 SETUP (exactly 1 cycle): m_psel=1, m_penable=0, m_paddr/m_pwrite/m_pwdata/m_pstrb valid; next state ACCESS.
REQ-019 ACCESS: m_psel=1, m_penable=1, signals unchanged; on m_pready=1 capture m_prdata and m_pslverr, drop psel/penable next cycle, go RESP.
REQ-020 ACCESS timeout counter SHALL start at 0 on ACCESS entry; if it reaches TIMEOUT with m_pready=0, transfer ends (psel/penable low next cycle), status=error, go RESP.
REQ-021 m_pstrb SHALL be 4'hF for writes and 4'h0 for reads; m_pprot SHALL be 3'b000; m_pwdata SHALL be 0 for reads.
REQ-022 RESP: status byte 0x4B on success, 0x45 on pslverr or timeout; successful read appends prdata as 4 bytes MSB first; all others send status only.
REQ-023 Each response byte SHALL be presented with tx_valid=1 and advance only on tx_valid&tx_ready; after last byte accepted, tx_valid drops same edge and state returns IDLE.
REQ-024 rx_valid in SETUP, ACCESS, RESP SHALL be ignored (byte dropped, no state change).
REQ-025 Back-to-back frames SHALL be accepted: a command byte arriving the cycle after return to IDLE is processed normally.
REQ-026 Outside SETUP/ACCESS, m_psel and m_penable SHALL be 0; m_paddr holds last value.
REQ-027 Latency: SETUP entered the cycle after the final frame byte; first tx_valid asserted the cycle after the APB completion cycle.

Reset
REQ-028 resetn low SHALL immediately force state IDLE, counters 0, busy=0, tx_valid=0, tx_data=0, m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, m_pstrb=0, m_pprot=0.
REQ-029 Reset mid-frame or mid-APB-transfer SHALL abandon the frame without any response byte; first byte after release is treated as a command byte.

Verification
REQ-030 Write: 57 00 00 10 04 DE AD BE EF, pready after 2 ACCESS cycles -> one APB write addr 0x00001004, data 0xDEADBEEF, pstrb F; tx byte 0x4B.
REQ-031 Read: 52 00 00 00 08, completer returns 0x12345678 pready=1 first ACCESS cycle -> APB read 0x00000008, pstrb 0; tx 4B 12 34 56 78.
REQ-032 Error/timeout: write with pslverr=1 -> tx 0x45; read with TIMEOUT=15 and pready stuck 0 -> psel drops after 15 ACCESS cycles, tx 0x45 only.
REQ-033 Bad command 0x41 -> no APB activity, tx 0x3F; tx_ready held low 20 cycles -> tx_valid/tx_data stable throughout.
REQ-034 Reset asserted during ACCESS of a read -> psel/penable/tx_valid 0 asynchronously; following valid write frame completes with 0x4B.
REQ-035 Bytes injected during ACCESS/RESP -> ignored; response and next frame unaffected.
